// File: rtl/loss_grad_collector.sv
// Collects the loss stage's two skewed gradient columns into rows, buffers them
// in a show-ahead FIFO and hands them to the unified-buffer writer per batch.
module loss_grad_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic [COUNT_WIDTH-1:0] batch_size_in,
    input  logic [DATA_WIDTH-1:0]  gradient_1_in,
    input  logic [DATA_WIDTH-1:0]  gradient_2_in,
    input  logic                   valid_1_in,
    input  logic                   valid_2_in,
    output logic [DATA_WIDTH-1:0]  row_grad_1_out,
    output logic [DATA_WIDTH-1:0]  row_grad_2_out,
    output logic [COUNT_WIDTH-1:0] row_index_out,
    output logic                   row_valid_out,
    input  logic                   row_ready_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_COLLECT = 2'd1;
    localparam logic [1:0] STATE_DRAIN   = 2'd2;
    localparam logic [1:0] STATE_DONE    = 2'd3;

    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] batch_size;
    logic [COUNT_WIDTH-1:0] rows_in;
    logic [COUNT_WIDTH-1:0] rows_next;

    logic [DATA_WIDTH-1:0]  pend_data [2];
    logic [1:0]             pend_count;
    logic                   pend_slot;

    logic [DATA_WIDTH-1:0]  fifo_g1  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_g2  [FIFO_DEPTH];
    logic [COUNT_WIDTH-1:0] fifo_idx [FIFO_DEPTH];
    logic [PTR_WIDTH:0]     wr_ptr;
    logic [PTR_WIDTH:0]     rd_ptr;
    logic                   fifo_empty;
    logic                   fifo_full;

    logic collecting, start_ok, stray_beat;
    logic pend_pop, bypass, orphan, pend_push_req, pend_overflow, pend_push;
    logic pair_valid;
    logic [DATA_WIDTH-1:0] pair_g1;
    logic fifo_pop, fifo_push, fifo_drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                        (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

    assign collecting = (state == STATE_COLLECT);
    assign start_ok   = (state == STATE_IDLE) && start_in;
    assign stray_beat = !collecting && (valid_1_in || valid_2_in);

    // Column 2 always pairs with the oldest column-1 beat; bypass covers skew 0.
    assign pend_pop      = collecting && valid_2_in && (pend_count != 2'd0);
    assign bypass        = collecting && valid_2_in && (pend_count == 2'd0) && valid_1_in;
    assign orphan        = collecting && valid_2_in && (pend_count == 2'd0) && !valid_1_in;
    assign pend_push_req = collecting && valid_1_in && !bypass;
    assign pend_overflow = pend_push_req && (pend_count == 2'd2) && !pend_pop;
    assign pend_push     = pend_push_req && !pend_overflow;
    assign pend_slot     = (pend_count == 2'd2) || ((pend_count == 2'd1) && !pend_pop);

    assign pair_valid = pend_pop || bypass;
    assign pair_g1    = pend_pop ? pend_data[0] : gradient_1_in;
    assign rows_next  = rows_in + {{(COUNT_WIDTH-1){1'b0}}, pair_valid};

    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign fifo_pop  = !fifo_empty && row_ready_in;
    assign fifo_push = pair_valid && (!fifo_full || fifo_pop);
    assign fifo_drop = pair_valid && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= STATE_IDLE;
            batch_size <= '0;
            rows_in    <= '0;
            pend_count <= 2'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            error_out  <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (start_in) begin
                        if (batch_size_in != '0) begin
                            state      <= STATE_COLLECT;
                            batch_size <= batch_size_in;
                        end else begin
                            state <= STATE_DONE;
                        end
                    end
                end
                STATE_COLLECT: if (rows_next == batch_size) state <= STATE_DRAIN;
                STATE_DRAIN:   if (fifo_empty) state <= STATE_DONE;
                default:       state <= STATE_IDLE;
            endcase

            rows_in    <= start_ok ? '0 : rows_next;
            pend_count <= start_ok ? 2'd0 : (pend_count - {1'b0, pend_pop} + {1'b0, pend_push});
            error_out  <= (start_ok ? 1'b0 : error_out) |
                          orphan | pend_overflow | fifo_drop | stray_beat;

            if (fifo_push) wr_ptr <= wr_ptr + {{PTR_WIDTH{1'b0}}, 1'b1};
            if (fifo_pop)  rd_ptr <= rd_ptr + {{PTR_WIDTH{1'b0}}, 1'b1};
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (pend_pop)  pend_data[0] <= pend_data[1];
        if (pend_push) pend_data[pend_slot] <= gradient_1_in;
        if (fifo_push) begin
            fifo_g1[wr_ptr[PTR_WIDTH-1:0]]  <= pair_g1;
            fifo_g2[wr_ptr[PTR_WIDTH-1:0]]  <= gradient_2_in;
            fifo_idx[wr_ptr[PTR_WIDTH-1:0]] <= rows_in;
        end
    end

    assign row_valid_out  = !fifo_empty;
    assign row_grad_1_out = row_valid_out ? fifo_g1[rd_ptr[PTR_WIDTH-1:0]]  : '0;
    assign row_grad_2_out = row_valid_out ? fifo_g2[rd_ptr[PTR_WIDTH-1:0]]  : '0;
    assign row_index_out  = row_valid_out ? fifo_idx[rd_ptr[PTR_WIDTH-1:0]] : '0;
    assign busy_out       = (state == STATE_COLLECT) || (state == STATE_DRAIN);
    assign done_out       = (state == STATE_DONE);

endmodule

// File: tb/tb_loss_grad_collector.sv
// Bench for loss_grad_collector: directed vector table, hand-written corner
// sequences and randomized batches compared against a queue-based model.
module tb_loss_grad_collector;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_in = 1'b0;
    logic [CW-1:0] batch_size_in = '0;
    logic [DW-1:0] gradient_1_in = '0;
    logic [DW-1:0] gradient_2_in = '0;
    logic          valid_1_in = 1'b0;
    logic          valid_2_in = 1'b0;
    logic          row_ready_in = 1'b0;
    logic [DW-1:0] row_grad_1_out;
    logic [DW-1:0] row_grad_2_out;
    logic [CW-1:0] row_index_out;
    logic          row_valid_out;
    logic          busy_out;
    logic          done_out;
    logic          error_out;

    always #5 clk = ~clk;

    loss_grad_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .batch_size_in(batch_size_in),
        .gradient_1_in(gradient_1_in), .gradient_2_in(gradient_2_in),
        .valid_1_in(valid_1_in), .valid_2_in(valid_2_in),
        .row_grad_1_out(row_grad_1_out), .row_grad_2_out(row_grad_2_out),
        .row_index_out(row_index_out), .row_valid_out(row_valid_out),
        .row_ready_in(row_ready_in), .busy_out(busy_out), .done_out(done_out),
        .error_out(error_out)
    );

    typedef struct {
        logic [DW-1:0] g1;
        logic [DW-1:0] g2;
        logic [CW-1:0] idx;
    } row_t;

    typedef struct {
        logic st; logic [CW-1:0] bs;
        logic v1; logic [DW-1:0] g1; logic v2; logic [DW-1:0] g2; logic rdy;
        logic e_valid; logic [DW-1:0] e_g1; logic [DW-1:0] e_g2; logic [CW-1:0] e_idx;
        logic e_busy; logic e_done; logic e_err;
    } vec_t;

    // Model: 0 idle, 1 collect, 2 drain, 3 done.
    row_t          m_fifo[$];
    logic [DW-1:0] m_pend[$];
    int            m_state = 0;
    logic [CW-1:0] m_batch = '0;
    logic [CW-1:0] m_rows = '0;
    logic          m_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle_no, actual, expected);
        end
    endtask

    task automatic model_step(input logic st, input logic [CW-1:0] bs, input logic v1,
                              input logic [DW-1:0] g1, input logic v2, input logic [DW-1:0] g2,
                              input logic rdy);
        int pre_state;
        bit pre_nonempty, bypass, have_pair;
        logic [DW-1:0] pg1;
        row_t r;
        pg1 = '0;
        have_pair = 0;
        if (!rst) begin
            m_fifo.delete(); m_pend.delete();
            m_state = 0; m_batch = '0; m_rows = '0; m_err = 1'b0;
            return;
        end
        pre_state = m_state;
        pre_nonempty = (m_fifo.size() != 0);
        if (pre_nonempty && rdy) void'(m_fifo.pop_front());
        case (pre_state)
            0: begin
                if (st) begin
                    m_err = 1'b0;
                    m_pend.delete();
                    if (bs != 0) begin m_batch = bs; m_rows = '0; m_state = 1; end
                    else m_state = 3;
                end
                if (v1 || v2) m_err = 1'b1;
            end
            1: begin
                bypass = v2 && (m_pend.size() == 0) && v1;
                if (v2) begin
                    if (m_pend.size() != 0) begin pg1 = m_pend.pop_front(); have_pair = 1; end
                    else if (v1) begin pg1 = g1; have_pair = 1; end
                    else m_err = 1'b1;
                end
                if (v1 && !bypass) begin
                    if (m_pend.size() < 2) m_pend.push_back(g1);
                    else m_err = 1'b1;
                end
                if (have_pair) begin
                    if (m_fifo.size() < DEPTH) begin
                        r.g1 = pg1; r.g2 = g2; r.idx = m_rows;
                        m_fifo.push_back(r);
                    end else m_err = 1'b1;
                    m_rows = m_rows + 1'b1;
                end
                if (m_rows == m_batch) m_state = 2;
            end
            2: begin
                if (v1 || v2) m_err = 1'b1;
                if (!pre_nonempty) m_state = 3;
            end
            default: begin
                if (v1 || v2) m_err = 1'b1;
                m_state = 0;
            end
        endcase
    endtask

    task automatic check_output();
        row_t h;
        bit ev;
        ev = (m_fifo.size() != 0);
        h.g1 = '0; h.g2 = '0; h.idx = '0;
        if (ev) h = m_fifo[0];
        check("row_valid", {31'd0, row_valid_out}, {31'd0, ev});
        check("row_grad_1", {16'd0, row_grad_1_out}, {16'd0, h.g1});
        check("row_grad_2", {16'd0, row_grad_2_out}, {16'd0, h.g2});
        check("row_index", {24'd0, row_index_out}, {24'd0, h.idx});
        check("busy", {31'd0, busy_out}, {31'd0, (m_state == 1 || m_state == 2)});
        check("done", {31'd0, done_out}, {31'd0, (m_state == 3)});
        check("error", {31'd0, error_out}, {31'd0, m_err});
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1ns later.
    task automatic apply_stimulus(input logic st, input logic [CW-1:0] bs, input logic v1,
                                  input logic [DW-1:0] g1, input logic v2, input logic [DW-1:0] g2,
                                  input logic rdy);
        start_in = st; batch_size_in = bs;
        valid_1_in = v1; gradient_1_in = g1;
        valid_2_in = v2; gradient_2_in = g2;
        row_ready_in = rdy;
        @(posedge clk);
        model_step(st, bs, v1, g1, v2, g2, rdy);
        #1;
        cycle_no++;
        check_output();
    endtask

    task automatic idle_cycle(input logic rdy);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    function automatic vec_t mk(input logic st, input logic [CW-1:0] bs, input logic v1,
                                input logic [DW-1:0] g1, input logic v2, input logic [DW-1:0] g2,
                                input logic rdy, input logic ev, input logic [DW-1:0] eg1,
                                input logic [DW-1:0] eg2, input logic [CW-1:0] eidx,
                                input logic eb, input logic ed, input logic ee);
        vec_t v;
        v.st = st; v.bs = bs; v.v1 = v1; v.g1 = g1; v.v2 = v2; v.g2 = g2; v.rdy = rdy;
        v.e_valid = ev; v.e_g1 = eg1; v.e_g2 = eg2; v.e_idx = eidx;
        v.e_busy = eb; v.e_done = ed; v.e_err = ee;
        return v;
    endfunction

    task automatic check_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        check({tag, "_valid"}, {31'd0, row_valid_out}, {31'd0, v.e_valid});
        check({tag, "_g1"}, {16'd0, row_grad_1_out}, {16'd0, v.e_g1});
        check({tag, "_g2"}, {16'd0, row_grad_2_out}, {16'd0, v.e_g2});
        check({tag, "_idx"}, {24'd0, row_index_out}, {24'd0, v.e_idx});
        check({tag, "_busy"}, {31'd0, busy_out}, {31'd0, v.e_busy});
        check({tag, "_done"}, {31'd0, done_out}, {31'd0, v.e_done});
        check({tag, "_err"}, {31'd0, error_out}, {31'd0, v.e_err});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit finished;
        logic r_st, r_v1, r_v2, r_rdy;

        // Skew-1 stream, skew-0 bypass, zero batch.
        vecs.push_back(mk(1, 3, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0100, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0200, 1, 16'hFF00, 1, 1, 16'h0100, 16'hFF00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0300, 1, 16'hFE00, 1, 1, 16'h0200, 16'hFE00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hFD00, 1, 1, 16'h0300, 16'hFD00, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0005, 1, 16'hFFFB, 1, 1, 16'h0005, 16'hFFFB, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0007, 1, 16'hFFF9, 1, 1, 16'h0007, 16'hFFF9, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));

        rst = 1'b0;
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        rst = 1'b1;
        idle_cycle(1'b0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].st, vecs[i].bs, vecs[i].v1, vecs[i].g1,
                           vecs[i].v2, vecs[i].g2, vecs[i].rdy);
            check_vec(vecs[i], i);
        end

        // Backpressure: six rows into a four-deep FIFO with ready low.
        apply_stimulus(1'b1, 8'd6, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++)
            apply_stimulus(1'b0, '0, 1'b1, 16'(i + 1), 1'b1, 16'(16'h8000 + i), 1'b0);
        check("bp_err", {31'd0, error_out}, 32'd1);
        check("bp_head_idx", {24'd0, row_index_out}, 32'd0);
        check("bp_head_g1", {16'd0, row_grad_1_out}, 32'd1);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("bp_hold_idx", {24'd0, row_index_out}, 32'd0);
        check("bp_hold_g2", {16'd0, row_grad_2_out}, 32'h8000);
        for (int k = 1; k < 4; k++) begin
            idle_cycle(1'b1);
            check("bp_drain_idx", {24'd0, row_index_out}, 32'(k));
        end
        idle_cycle(1'b1);
        check("bp_empty", {31'd0, row_valid_out}, 32'd0);
        idle_cycle(1'b1);
        check("bp_done", {31'd0, done_out}, 32'd1);
        idle_cycle(1'b1);
        check("bp_busy_low", {31'd0, busy_out}, 32'd0);
        check("bp_err_sticky", {31'd0, error_out}, 32'd1);

        // Protocol error: column 2 with no column-1 beat pending.
        apply_stimulus(1'b1, 8'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        check("pe_err_cleared", {31'd0, error_out}, 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 16'h1234, 1'b1);
        check("pe_orphan_err", {31'd0, error_out}, 32'd1);
        check("pe_no_row", {31'd0, row_valid_out}, 32'd0);
        apply_stimulus(1'b0, '0, 1'b1, 16'h0011, 1'b1, 16'h0022, 1'b1);
        check("pe_row_g2", {16'd0, row_grad_2_out}, 32'h0022);
        repeat (3) idle_cycle(1'b1);
        apply_stimulus(1'b1, 8'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        check("pe_start_clears", {31'd0, error_out}, 32'd0);
        apply_stimulus(1'b0, '0, 1'b1, 16'h0033, 1'b1, 16'h0044, 1'b1);
        repeat (3) idle_cycle(1'b1);

        // Reset mid-batch with one row sitting in the FIFO.
        apply_stimulus(1'b1, 8'd4, 1'b0, '0, 1'b0, '0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 16'h0003, 1'b1, 16'h0004, 1'b1);
        check("rst_pre_valid", {31'd0, row_valid_out}, 32'd1);
        rst = 1'b0;
        idle_cycle(1'b1);
        check("rst_valid", {31'd0, row_valid_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_idx", {24'd0, row_index_out}, 32'd0);
        rst = 1'b1;
        apply_stimulus(1'b1, 8'd1, 1'b0, '0, 1'b0, '0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 16'h0AAA, 1'b1, 16'h0BBB, 1'b1);
        check("rst_new_idx", {24'd0, row_index_out}, 32'd0);
        check("rst_new_g1", {16'd0, row_grad_1_out}, 32'h0AAA);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        check("rst_new_done", {31'd0, done_out}, 32'd1);
        idle_cycle(1'b1);

        // Randomized batches against the model.
        for (int b = 0; b < 10; b++) begin
            apply_stimulus(1'b1, CW'($urandom_range(1, 10)), 1'b0, '0, 1'b0, '0, 1'b1);
            finished = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                if (m_state == 0) begin
                    finished = 1;
                    break;
                end
                if (cyc < 80) begin
                    r_st  = ($urandom_range(0, 15) == 0);
                    r_v1  = 1'($urandom_range(0, 1));
                    r_v2  = 1'($urandom_range(0, 1));
                    r_rdy = ($urandom_range(0, 9) < 7);
                end else begin
                    r_st = 1'b0; r_v1 = 1'b1; r_v2 = 1'b1; r_rdy = 1'b1;
                end
                apply_stimulus(r_st, CW'($urandom_range(0, 10)), r_v1, 16'($urandom),
                               r_v2, 16'($urandom), r_rdy);
            end
            if (!finished) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_batch_timeout: batch %0d still state %0d, required 0", b, m_state);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loss_grad_collector.md
Name: loss_grad_collector

Overview:
- Receiver for the two-column loss stage's gradient outputs: gradient_1/valid_1 (column 1) and gradient_2/valid_2 (column 2, skewed 0 or 1 cycle behind column 1).
- De-skews the two columns and pairs them into rows, buffers the rows in a FIFO, and presents them to the unified-buffer write side over a valid/ready handshake.
- Counts rows against a programmed batch size and signals completion once the batch is drained.
- The loss stage cannot be stalled, so overflow and protocol violations are flagged in a sticky error, never back-pressured.

Parameters:
- DATA_WIDTH, 16, gradient width (signed fixed-point, passed through unmodified).
- FIFO_DEPTH, 4, depth of the assembled-row FIFO; power of two, at least 2.
- COUNT_WIDTH, 8, width of the batch size and row counters.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-low reset (asserted when 0).
- start_in, input, 1, one-cycle pulse; latches batch_size_in and begins collection.
- batch_size_in, input, COUNT_WIDTH, number of rows expected in the batch.
- gradient_1_in, input, DATA_WIDTH, column-1 gradient.
- gradient_2_in, input, DATA_WIDTH, column-2 gradient.
- valid_1_in, input, 1, gradient_1_in is valid this cycle.
- valid_2_in, input, 1, gradient_2_in is valid this cycle.
- row_grad_1_out, output, DATA_WIDTH, column-1 gradient of the FIFO head row.
- row_grad_2_out, output, DATA_WIDTH, column-2 gradient of the FIFO head row.
- row_index_out, output, COUNT_WIDTH, row number (0-based) of the head row.
- row_valid_out, output, 1, head row is available.
- row_ready_in, input, 1, consumer accepts the head row.
- busy_out, output, 1, high in COLLECT and DRAIN.
- done_out, output, 1, one-cycle pulse when the batch is fully drained.
- error_out, output, 1, sticky error flag; cleared only by reset or start_in.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; FIFO, pending queue and counters are cleared.
  - All outputs are 0. Reset applies mid-batch with no residue.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE: start_in=1 and batch_size_in!=0 → COLLECT. Latch the batch size, clear error_out, rows_in=0, out_idx=0.
  - IDLE: start_in=1 and batch_size_in=0 → DONE, with no rows.
  - COLLECT: when rows_in reaches the batch size at an edge → DRAIN.
  - DRAIN: when the FIFO is empty → DONE.
  - DONE: lasts one cycle with done_out=1, then → IDLE.
  - busy_out = (state==COLLECT or state==DRAIN).
  - start_in outside IDLE is ignored.
- Pending column-1 queue (depth 2), COLLECT only:
  - valid_1_in=1 pushes gradient_1_in.
  - valid_2_in=1 pairs gradient_2_in with the oldest pending column-1 entry.
  - Same-cycle bypass: if the queue is empty and valid_1_in and valid_2_in are both 1, they pair directly (skew 0).
  - Both valids with a non-empty queue: pop the head and push the new column-1 entry in the same cycle.
  - valid_2_in with no column-1 available → error_out=1, beat discarded.
  - Push into a full pending queue → error_out=1, beat discarded.
- Row assembly:
  - A paired row is written into the FIFO at the same edge, with index = rows_in; rows_in then increments.
  - Latency: valid_2_in sampled at edge k gives row_valid_out=1 after edge k, provided the FIFO was empty.
- Output FIFO (show-ahead):
  - row_* outputs reflect the head entry; row_valid_out = FIFO not empty.
  - Pop when row_valid_out and row_ready_in are both 1.
  - row_* outputs hold stable while valid and not ready.
  - Push when full with a pop in the same cycle: the push is accepted.
  - Push when full without a pop: error_out=1, row dropped, rows_in still increments so the batch terminates.
- Out-of-state beats: valid_1_in or valid_2_in in IDLE, DRAIN or DONE → error_out=1, data ignored.
- Arithmetic:
  - No arithmetic on data; gradients pass through bit-exact.
  - Counters wrap at 2^COUNT_WIDTH; batch sizes at or above 2^COUNT_WIDTH are not supported.

Test Plan:
- Skew-1 stream: start, batch=3. Column-1 beats 0x0100, 0x0200, 0x0300 on cycles 1-3; column-2 beats 0xFF00, 0xFE00, 0xFD00 on cycles 2-4; ready held at 1.
  → Rows (0x0100,0xFF00,idx0), (0x0200,0xFE00,idx1), (0x0300,0xFD00,idx2), each valid one cycle after its column-2 beat. done_out pulses once; error_out stays 0.
- Skew-0 bypass: batch=2, both valids together on two cycles with values (5,-5) and (7,-7).
  → Rows (5,-5,idx0) and (7,-7,idx1). DONE is reached; busy_out falls.
- Backpressure: batch=6, ready=0 throughout collection, FIFO_DEPTH=4.
  → First 4 rows are held stable; rows 5-6 are dropped; error_out=1. Then raise ready.
  → The 4 rows drain in order, idx 0-3, followed by done_out.
- Protocol error: in COLLECT, valid_2_in=1 with no prior column-1 beat.
  → error_out=1, no row is pushed. A following start_in in IDLE clears error_out.
- Reset mid-batch: rst=0 after 2 of 4 rows, with one row in the FIFO.
  → Next cycle: row_valid_out=0, busy_out=0, row_index_out=0. A new batch (batch=1) then completes normally with idx0.
- Zero batch: start_in with batch_size_in=0.
  → done_out pulses the cycle after start; busy_out is never asserted.
